// File: rtl/fifo_rd_pkg.sv
// Shared defaults and helpers for the FIFO-to-stream read engine.
package fifo_rd_pkg;
   localparam int DEF_DATA_W = 128;
   localparam int DEF_RD_LAT = 1;
   localparam int DEF_SKID_D = 3;
   localparam int RD_LAT_MAX = 2;
   localparam int BEAT_W     = 16;

   // Number of reads still in flight, from the zero-padded pending vector.
   function automatic logic [1:0] pend_count(input logic [RD_LAT_MAX-1:0] pend);
      pend_count = {1'b0, pend[0]} + {1'b0, pend[1]};
   endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying beats out of the FIFO read engine.
interface fifo_rd_stream_if #(
   parameter int DATA_W = 128
);
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_skidbuf.sv
// Circular holding buffer that absorbs reads already issued to the FIFO.
module fifo_rd_skidbuf #(
   parameter int  DATA_W = 128,
   parameter int  SKID_D = 3,
   localparam int LVL_W  = $clog2(SKID_D + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [LVL_W-1:0]  level
);
   localparam int PTR_W = $clog2(SKID_D);

   logic [DATA_W-1:0] mem_q [SKID_D];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_W'(SKID_D - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state pointers and occupancy; a simultaneous write and read keeps level.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_en) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is never reset; level alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// Issues FIFO reads against buffer credit and presents returned data as a stream.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  RD_LAT = DEF_RD_LAT,
   parameter int  SKID_D = DEF_SKID_D,
   localparam int LVL_W  = $clog2(SKID_D + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  logic              fifo_empty,
   input  logic              fifo_alm_empty,
   input  logic [DATA_W-1:0] fifo_rddata,
   output logic              fifo_rden,
   fifo_rd_stream_if.master  m_if,
   output logic [LVL_W-1:0]  o_level,
   output logic [BEAT_W-1:0] o_beat_cnt,
   output logic              o_starved
);
   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || SKID_D < RD_LAT + 2) begin : g_bad_cfg
      $error("fifo_rd_stream: SKID_D must be at least RD_LAT+2 and RD_LAT must be 1..2");
   end

   logic [RD_LAT-1:0]     pend_q, pend_d;
   logic [RD_LAT_MAX-1:0] pend_pad_s;
   logic [1:0]            pend_cnt_s;
   logic [LVL_W+1:0]      credit_used_s;
   logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                  starved_q, starved_d;
   logic [LVL_W-1:0]      level_s;
   logic [DATA_W-1:0]     head_s;
   logic                  rden_s, capture_s, valid_s, pop_s;

   // Credit counts in-flight reads so a capture can never land in a full buffer;
   // m_ready is deliberately kept out of this path.
   always_comb begin
      pend_pad_s = '0;
      pend_pad_s[RD_LAT-1:0] = pend_q;
      pend_cnt_s    = pend_count(pend_pad_s);
      credit_used_s = (LVL_W+2)'(level_s) + (LVL_W+2)'(pend_cnt_s);
      rden_s    = reset && i_en && !fifo_empty && (credit_used_s < (LVL_W+2)'(SKID_D));
      capture_s = pend_q[RD_LAT-1];
      valid_s   = (level_s != '0);
      pop_s     = valid_s && m_if.m_ready;
      pend_d    = RD_LAT'({pend_q, rden_s});
      if (pop_s) begin
         beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end else begin
         beat_cnt_d = beat_cnt_q;
      end
      starved_d = !valid_s && fifo_alm_empty && i_en;
   end

   // Pending pipeline and counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q     <= '0;
         beat_cnt_q <= '0;
         starved_q  <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         beat_cnt_q <= beat_cnt_d;
         starved_q  <= starved_d;
      end
   end

   fifo_rd_skidbuf #(
      .DATA_W (DATA_W),
      .SKID_D (SKID_D)
   ) u_skidbuf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (capture_s),
      .wr_data (fifo_rddata),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .level   (level_s)
   );

   assign fifo_rden   = rden_s;
   assign m_if.m_valid = valid_s;
   assign m_if.m_data  = head_s;
   assign o_level     = level_s;
   assign o_beat_cnt  = beat_cnt_q;
   assign o_starved   = starved_q;
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_W, 128, width of the FIFO read data and the stream data.
REQ-002 Parameter RD_LAT, 1, FIFO read latency in cycles from fifo_rden to valid fifo_rddata; legal values are 1..2.
REQ-003 Parameter SKID_D, 3, holding-buffer depth; the block SHALL reject SKID_D < RD_LAT+2 at elaboration.
REQ-004 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-low reset.
REQ-006 Port i_en, input, 1, enables issue of new FIFO reads.
REQ-007 Port fifo_empty, input, 1, FIFO empty flag.
REQ-008 Port fifo_alm_empty, input, 1, FIFO almost-empty flag; status only.
REQ-009 Port fifo_rddata, input, DATA_W, FIFO read data.
REQ-010 Port fifo_rden, output, 1, FIFO read enable.
REQ-011 Port m_valid, output, 1, stream beat valid.
REQ-012 Port m_data, output, DATA_W, stream beat data.
REQ-013 Port m_ready, input, 1, stream sink ready.
REQ-014 Port o_level, output, $clog2(SKID_D+1), current holding-buffer occupancy.
REQ-015 Port o_beat_cnt, output, 16, count of accepted stream beats.
REQ-016 Port o_starved, output, 1, registered (m_valid==0 && fifo_alm_empty==1 && i_en==1).

Function
REQ-017 The block SHALL assert fifo_rden = i_en && !fifo_empty && (level + pend) < SKID_D, where pend is the number of issued reads whose data has not yet returned.
REQ-018 fifo_rden SHALL have no combinational path from m_ready.
REQ-019 The block SHALL never assert fifo_rden while fifo_empty is 1.
REQ-020 The block SHALL track issued reads in an RD_LAT-stage pending shift register and SHALL capture fifo_rddata exactly RD_LAT cycles after each fifo_rden.
REQ-021 The holding buffer SHALL be a circular buffer of SKID_D entries with wrap-around read and write pointers modulo SKID_D.
REQ-022 The block SHALL drive m_valid = (level != 0) and m_data = the head entry.
REQ-023 A pop SHALL occur only when m_valid && m_ready; m_data SHALL stay stable while m_valid && !m_ready.
REQ-024 On a simultaneous capture and pop, level SHALL be unchanged and both pointers SHALL advance.
REQ-025 The credit rule in REQ-017 SHALL guarantee that a capture never occurs while level == SKID_D.
REQ-026 Bypass SHALL not be implemented: the latency from fifo_rden to m_valid is RD_LAT+1 cycles.
REQ-027 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain one beat per cycle.
REQ-028 When i_en deasserts, the block SHALL issue no new reads, SHALL still capture in-flight reads, and SHALL drain them normally.
REQ-029 o_beat_cnt SHALL increment by 1 on each pop and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-030 While reset is 0 at a rising edge, the block SHALL set fifo_rden=0, m_valid=0, o_level=0, o_beat_cnt=0 and o_starved=0, and SHALL clear the pointers and the pending register.
REQ-031 A reset asserted mid-operation SHALL discard buffered beats and in-flight reads; fifo_rddata returned after reset SHALL NOT be captured.
REQ-032 m_data is don't-care after reset; the implementation SHALL NOT reset the storage array.

Structure
REQ-033 Package fifo_rd_pkg SHALL hold the DATA_W, RD_LAT and SKID_D defaults and the beat-counter width localparam BEAT_W=16.
REQ-034 The storage array, pointers and level counter SHALL live in the sub-module fifo_rd_skidbuf; fifo_rd_stream SHALL hold the issue/credit logic, the pending register and the counters.

Verification
REQ-035 Streaming test: FIFO preloaded with 8 beats 0x1..0x8, i_en=1, m_ready=1 -> first m_valid 2 cycles after the first fifo_rden, beats 0x1..0x8 on consecutive cycles, o_beat_cnt=8.
REQ-036 Backpressure test: m_ready=0 with a 10-entry FIFO -> exactly 3 fifo_rden pulses, o_level=3, m_data=first beat held stable; then release m_ready -> remaining beats arrive in order with none lost or duplicated.
REQ-037 Empty FIFO test: fifo_empty=1 and i_en=1 -> fifo_rden=0 always; o_starved=1 once fifo_alm_empty=1.
REQ-038 Enable-off test: deassert i_en in the same cycle as a fifo_rden -> that beat is still delivered and no further reads are issued.
REQ-039 Mid-stream reset test: reset=0 for 1 cycle with o_level=2 and one read pending -> next cycle m_valid=0, o_level=0, and the late fifo_rddata is not output.
REQ-040 Wrap test: preset o_beat_cnt to 16'hFFFE, then pass 3 beats -> o_beat_cnt=1.
